// File: rtl/instr_decode_queue.sv
// instr_decode_queue: decodes MIPS-style instructions on enqueue and buffers
// the decoded entries in a QDEPTH-deep FIFO; all outputs come from the head entry.
`default_nettype none

module instr_decode_queue #(
    parameter int QDEPTH = 4,
    parameter int PC_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    input  logic [PC_W-1:0]             in_pc,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PC_W-1:0]             out_pc,
    output logic [4:0]                  rs,
    output logic [4:0]                  rt,
    output logic [4:0]                  rd,
    output logic [31:0]                 imm_ext,
    output logic [25:0]                 jaddr,
    output logic                        reg_dst,
    output logic                        branch,
    output logic                        mem_read,
    output logic                        mem_to_reg,
    output logic                        mem_write,
    output logic                        alu_src,
    output logic                        reg_write,
    output logic                        jump,
    output logic [1:0]                  alu_op,
    output logic                        illegal,
    output logic [$clog2(QDEPTH):0]     count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    // Control vector: {reg_dst, branch, mem_read, mem_to_reg, mem_write,
    //                  alu_src, reg_write, jump, alu_op[1:0], illegal}
    logic [5:0]  opcode;
    logic [10:0] dec_ctrl;
    logic [31:0] dec_imm;

    assign opcode  = in_instr[31:26];
    assign dec_imm = (opcode == 6'h0C) ? {16'b0, in_instr[15:0]}
                                       : {{16{in_instr[15]}}, in_instr[15:0]};

    always_comb begin
        dec_ctrl = 11'b0;
        case (opcode)
            6'h00:   dec_ctrl = 11'b10000010100;
            6'h23:   dec_ctrl = 11'b00110110000;
            6'h2B:   dec_ctrl = 11'b00001100000;
            6'h04:   dec_ctrl = 11'b01000000010;
            6'h02:   dec_ctrl = 11'b00000001000;
            6'h08:   dec_ctrl = 11'b00000110000;
            6'h0C:   dec_ctrl = 11'b00000110110;
            default: dec_ctrl = 11'b00000000001;
        endcase
    end

    logic [25:0]     mem_field [QDEPTH];
    logic [31:0]     mem_imm   [QDEPTH];
    logic [10:0]     mem_ctrl  [QDEPTH];
    logic [PC_W-1:0] mem_pc    [QDEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    assign in_ready  = (state != S_FULL) && !flush;
    assign out_valid = (state != S_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;

        if (count_next == '0)
            state_next = S_EMPTY;
        else if (count_next == FULL_CNT)
            state_next = S_FULL;
        else
            state_next = S_PARTIAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= S_EMPTY;
        end else begin
            count <= count_next;
            state <= state_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to a bubble while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_field[wr_ptr] <= in_instr[25:0];
            mem_imm[wr_ptr]   <= dec_imm;
            mem_ctrl[wr_ptr]  <= dec_ctrl;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    logic [10:0] head_ctrl;

    always_comb begin
        out_pc    = '0;
        jaddr     = '0;
        imm_ext   = '0;
        head_ctrl = '0;
        if (out_valid) begin
            out_pc    = mem_pc[rd_ptr];
            jaddr     = mem_field[rd_ptr];
            imm_ext   = mem_imm[rd_ptr];
            head_ctrl = mem_ctrl[rd_ptr];
        end
    end

    assign rs = jaddr[25:21];
    assign rt = jaddr[20:16];
    assign rd = jaddr[15:11];
    assign {reg_dst, branch, mem_read, mem_to_reg, mem_write,
            alu_src, reg_write, jump, alu_op, illegal} = head_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed checks of decode, FIFO flow control, flush and async reset.
`default_nettype none

module tb_instr_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write;
    logic        alu_src, reg_write, jump, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_decode_queue #(.QDEPTH(4), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .jaddr(jaddr),
        .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .jump(jump),
        .alu_op(alu_op), .illegal(illegal), .count(count)
    );

    logic [10:0] ctrl;
    assign ctrl = {reg_dst, branch, mem_read, mem_to_reg, mem_write,
                   alu_src, reg_write, jump, alu_op, illegal};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty queue with out_ready=1 and check the decoded head.
    task automatic push_check(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [10:0] exp_ctrl, input logic [31:0] exp_imm);
        logic [31:0] w;
        w         = instr;
        in_instr  = instr;
        in_pc     = pc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_pc"},    out_pc,    pc);
        chk({tag, "_ctrl"},  ctrl,      exp_ctrl);
        chk({tag, "_imm"},   imm_ext,   exp_imm);
        chk({tag, "_regs"},  {rs, rt, rd}, {w[25:21], w[20:16], w[15:11]});
        chk({tag, "_jaddr"}, jaddr,     w[25:0]);
        step();
        chk({tag, "_bubble"}, {out_valid, ctrl, imm_ext, out_pc}, 76'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_fields", {ctrl, imm_ext, out_pc, jaddr}, 101'd0);
        #10 rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1'b1);

        push_check("lw",   32'h8C22FFFC, 32'h100, 11'b00110110000, 32'hFFFFFFFC);
        chk("lw_rs_rt", {rs, rt}, {5'd0, 5'd0});
        push_check("andi", 32'h30218000, 32'h104, 11'b00000110110, 32'h00008000);
        push_check("ill",  32'hFC001234, 32'h108, 11'b00000000001, 32'h00001234);
        push_check("rtyp", 32'h00430820, 32'h10C, 11'b10000010100, 32'h00000820);
        push_check("beq",  32'h10220004, 32'h110, 11'b01000000010, 32'h00000004);
        push_check("j",    32'h08000040, 32'h114, 11'b00000001000, 32'h00000040);
        push_check("sw",   32'hAC220008, 32'h118, 11'b00001100000, 32'h00000008);
        push_check("addi", 32'h2021FFFF, 32'h11C, 11'b00000110000, 32'hFFFFFFFF);

        // Fill past capacity with the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_instr = 32'h20000000 | i;
            in_pc    = 32'h200 + 4 * i;
            step();
            if (i == 3) begin
                chk("full_in_ready", in_ready, 1'b0);
                chk("full_count4", count, 3'd4);
            end
        end
        in_valid = 1'b0;
        chk("full_count_after5", count, 3'd4);
        chk("full_head_stable", out_pc, 32'h200);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 32'h200 + 4 * i);
            chk("drain_imm", imm_ext, i);
            step();
        end
        chk("drain_empty", {out_valid, count}, 4'd0);

        // Two entries, then ten cycles of concurrent push and pop across pointer wrap.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instr = 32'h20000000;
            in_pc    = 32'h300 + 4 * i;
            step();
        end
        chk("sim_count_start", count, 3'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h308 + 4 * k;
            chk("sim_head", out_pc, 32'h300 + 4 * k);
            step();
            chk("sim_count", count, 3'd2);
        end
        in_valid = 1'b0;
        chk("sim_tail0", out_pc, 32'h328);
        step();
        chk("sim_tail1", out_pc, 32'h32C);
        step();
        chk("sim_empty", out_valid, 1'b0);

        // Flush with a simultaneous push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h400 + 4 * i;
            step();
        end
        chk("fl_count3", count, 3'd3);
        in_pc = 32'h4FC;
        flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_after", {out_valid, count}, 4'd0);
        in_pc = 32'h500;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fl_next_head", {count, out_pc}, {3'd1, 32'h500});
        out_ready = 1'b1;
        step();
        chk("fl_drained", count, 3'd0);

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h600 + 4 * i;
            step();
        end
        in_valid = 1'b0;
        chk("ar_count3", count, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_immediate", {out_valid, count}, 4'd0);
        chk("ar_fields", {ctrl, out_pc}, 43'd0);
        #2 rst_n = 1'b1;
        in_pc = 32'h700;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ar_first_push", {count, out_pc}, {3'd1, 32'h700});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
